ahb_lite_master: RTL and testbench

Single-master AHB-Lite bus master. It converts simple command requests (address, write data, beat count, size) into AHB-Lite single or incrementing-burst transfers and returns one completion response per command. It sits between a local controller or DMA front end and the AHB-Lite interconnect.

---
 rtl/ahb_pkg.sv | 62 ++++++
 rtl/ahb_lite_master_if.sv | 27 ++
 rtl/ahb_burst_addr_gen.sv | 58 +++++
 rtl/ahb_lite_master.sv | 192 +++++++++++++++++++
 tb/tb_ahb_lite_master.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite codes and master state encoding.
package ahb_pkg;

    // Transfer type codes driven on HTRANS.
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    // Burst type codes driven on HBURST.
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Transfer size codes (log2 of bytes per beat).
    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    // Slave response codes.
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Data access, privileged, non-bufferable, non-cacheable.
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    // Master sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_BURST = 3'd2,
        ST_LAST  = 3'd3,
        ST_RESP  = 3'd4
    } ahb_state_e;

    // Fixed-length incrementing bursts get their own code; every other length is INCR.
    function automatic logic [2:0] burst_encode(input logic [7:0] len_eff);
        logic [2:0] code;
        case (len_eff)
            8'd1:    code = HBURST_SINGLE;
            8'd4:    code = HBURST_INCR4;
            8'd8:    code = HBURST_INCR8;
            8'd16:   code = HBURST_INCR16;
            default: code = HBURST_INCR;
        endcase
        return code;
    endfunction

    // Requested beat sizes wider than the data bus fall back to the full bus width.
    function automatic logic [2:0] clamp_size(input logic [2:0] size, input logic [2:0] max_size);
        return (size > max_size) ? max_size : size;
    endfunction

endpackage

// File: rtl/ahb_lite_master_if.sv
// AHB-Lite bus bundle between the single master and the interconnect.
interface ahb_lite_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HREADY;
    logic                  HRESP;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic [DATA_WIDTH-1:0] HWDATA;

    modport master (
        input  HREADY, HRESP, HRDATA,
        output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA
    );

    modport slave (
        output HREADY, HRESP, HRDATA,
        input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA
    );
endinterface

// File: rtl/ahb_burst_addr_gen.sv
// Beat address generator: holds HADDR/HSIZE/HBURST and counts remaining address phases.
module ahb_burst_addr_gen
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [2:0]            load_size,
    input  logic [7:0]            load_len,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [2:0]            size,
    output logic [2:0]            burst,
    output logic                  last_beat
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    logic [7:0]            len_eff;
    logic [7:0]            remaining_q;
    logic [ADDR_WIDTH-1:0] incr;

    // A zero beat count means a single beat.
    always_comb begin
        len_eff = (load_len == 8'd0) ? 8'd1 : load_len;
    end

    // Byte stride between consecutive beats.
    always_comb begin
        incr = ADDR_WIDTH'(1) << size;
    end

    // Load the first beat on accept, then advance one stride per accepted address phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr        <= '0;
            size        <= HSIZE_BYTE;
            burst       <= HBURST_SINGLE;
            remaining_q <= '0;
        end else if (load) begin
            addr        <= load_addr;
            size        <= clamp_size(load_size, MAX_SIZE);
            burst       <= burst_encode(len_eff);
            remaining_q <= len_eff - 8'd1;
        end else if (step) begin
            addr        <= addr + incr;
            remaining_q <= remaining_q - 8'd1;
        end
    end

    // The address phase currently on the bus is the final one of the burst.
    assign last_beat = (remaining_q == 8'd0);

endmodule

// File: rtl/ahb_lite_master.sv
// Single-master AHB-Lite front end: one command in, one burst on the bus, one response out.
//
// Command handshake: a command transfers on the rising HCLK edge where
// cmd_valid && cmd_ready are both high; cmd_ready is only high while the master
// is idle, and cmd_valid may be held without waiting for cmd_ready. The response
// is a one-cycle resp_valid pulse with no back-pressure; resp_rdata and resp_err
// are meaningful in that cycle.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahb_lite_master_if.master     bus,
    input  logic                  cmd_valid,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    output logic                  cmd_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output ahb_state_e            state_dbg
);

    ahb_state_e            state_q, state_d;
    htrans_e               htrans_q, htrans_d;
    logic                  hwrite_q;
    logic [DATA_WIDTH-1:0] hwdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  cmd_ready_q;

    logic                  accept;
    logic                  load;
    logic                  step;
    logic                  capture;
    logic                  err_set;

    logic [ADDR_WIDTH-1:0] haddr_w;
    logic [2:0]            hsize_w;
    logic [2:0]            hburst_w;
    logic                  last_beat;

    assign accept = cmd_valid && cmd_ready_q;

    ahb_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_addr_gen (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .load      (load),
        .step      (step),
        .load_addr (cmd_addr),
        .load_size (cmd_size),
        .load_len  (cmd_len),
        .addr      (haddr_w),
        .size      (hsize_w),
        .burst     (hburst_w),
        .last_beat (last_beat)
    );

    // Next state, next HTRANS and the datapath strobes for this cycle.
    always_comb begin
        state_d  = state_q;
        htrans_d = htrans_q;
        load     = 1'b0;
        step     = 1'b0;
        capture  = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load     = 1'b1;
                    htrans_d = HTRANS_NONSEQ;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // First address phase: no data phase of ours is in flight yet.
                if (bus.HREADY) begin
                    if (last_beat) begin
                        htrans_d = HTRANS_IDLE;
                        state_d  = ST_LAST;
                    end else begin
                        step     = 1'b1;
                        htrans_d = HTRANS_SEQ;
                        state_d  = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (bus.HRESP == HRESP_ERROR) begin
                    err_set = 1'b1;
                end
                if (!bus.HREADY && (bus.HRESP == HRESP_ERROR)) begin
                    // First cycle of an ERROR: withdraw the pending address phase.
                    htrans_d = HTRANS_IDLE;
                    state_d  = ST_LAST;
                end else if (bus.HREADY) begin
                    capture = 1'b1;
                    if (last_beat) begin
                        htrans_d = HTRANS_IDLE;
                        state_d  = ST_LAST;
                    end else begin
                        step     = 1'b1;
                        htrans_d = HTRANS_SEQ;
                    end
                end
            end
            ST_LAST: begin
                if (bus.HRESP == HRESP_ERROR) begin
                    err_set = 1'b1;
                end
                if (bus.HREADY) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                htrans_d = HTRANS_IDLE;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State, HTRANS and the idle indication that drives cmd_ready.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            htrans_q    <= HTRANS_IDLE;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            htrans_q    <= htrans_d;
            cmd_ready_q <= (state_d == ST_IDLE);
        end
    end

    // Command direction and write data, captured once per command.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
        end else if (load) begin
            hwrite_q <= cmd_write;
            hwdata_q <= cmd_write ? cmd_wdata : '0;
        end
    end

    // Response data and sticky error, cleared at each accept.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (load) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (capture && !hwrite_q) begin
                rdata_q <= bus.HRDATA;
            end
        end
    end

    assign bus.HADDR     = haddr_w;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = hsize_w;
    assign bus.HBURST    = hburst_w;
    assign bus.HPROT     = HPROT_DEFAULT;
    assign bus.HTRANS    = htrans_q;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = hwdata_q;

    assign cmd_ready  = cmd_ready_q;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: AHB slave model, command driver, response scoreboard.
module tb_ahb_lite_master;
    import ahb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;
    int   cyc    = 0;

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [7:0]    cmd_len   = '0;
    logic [2:0]    cmd_size  = '0;
    logic          cmd_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    ahb_state_e    state_dbg;

    ahb_lite_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ahb_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .bus        (bus),
        .cmd_valid  (cmd_valid),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_len    (cmd_len),
        .cmd_size   (cmd_size),
        .cmd_ready  (cmd_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;

    logic [DW:0] exp_q[$];       // {err, rdata}
    logic [40:0] exp_addr_q[$];  // {htrans, hwrite, hsize, hburst, haddr}
    int          lat_q[$];

    int            accept_cyc = 0;
    logic [DW-1:0] cur_wdata  = '0;
    int            err_beat   = -1;
    int            wait_beat  = -1;
    int            wait_n     = 0;
    bit            rand_waits = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: list of accepted address phases, response and latency.
    task automatic push_model(input bit wr, input logic [AW-1:0] addr, input int len,
                              input int size, input int eb);
        int            len_eff;
        int            sz;
        int            nb;
        bit            err;
        logic [2:0]    bt;
        logic [AW-1:0] a;
        len_eff = (len == 0) ? 1 : len;
        sz      = (size > 2) ? 2 : size;
        case (len_eff)
            1:       bt = 3'b000;
            4:       bt = 3'b011;
            8:       bt = 3'b101;
            16:      bt = 3'b111;
            default: bt = 3'b001;
        endcase
        err = (eb >= 0) && (eb < len_eff);
        nb  = err ? eb + 1 : len_eff;
        a   = addr;
        for (int n = 0; n < nb; n++) begin
            a = addr + AW'(n * (1 << sz));
            exp_addr_q.push_back({((n == 0) ? 2'b10 : 2'b11), wr, 3'(sz), bt, a});
        end
        exp_q.push_back({err, (wr ? {DW{1'b0}} : (32'hABCD0000 + a))});
        lat_q.push_back(nb + 1);
    endtask

    // ---------------- driver tasks (called just after a rising edge) ----------------
    task automatic wait_ready();
        int t = 0;
        while (!cmd_ready && t < 300) begin
            @(posedge HCLK);
            #1;
            t++;
        end
        check("cmd_ready_timeout", 64'(cmd_ready), 64'(1));
    endtask

    task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int len, input int size, input int eb, input int wb, input int wn);
        wait_ready();
        if (!cmd_ready) return;
        err_beat  = eb;
        wait_beat = wb;
        wait_n    = wn;
        cur_wdata = wd;
        push_model(wr, addr, len, size, eb);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_len   = 8'(len);
        cmd_size  = 3'(size);
        cmd_valid = 1'b1;
        @(posedge HCLK);
        #1;
        accept_cyc = cyc;
        cmd_valid  = 1'b0;
        // Fields must be ignored after accept.
        cmd_write  = 1'($urandom_range(0, 1));
        cmd_addr   = $urandom;
        cmd_wdata  = $urandom;
        cmd_len    = 8'($urandom_range(0, 255));
        cmd_size   = 3'($urandom_range(0, 7));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_haddr"},      64'(bus.HADDR),     64'(0));
        check({tag, "_hwrite"},     64'(bus.HWRITE),    64'(0));
        check({tag, "_hsize"},      64'(bus.HSIZE),     64'(0));
        check({tag, "_hburst"},     64'(bus.HBURST),    64'(0));
        check({tag, "_hprot"},      64'(bus.HPROT),     64'(4'b0011));
        check({tag, "_htrans"},     64'(bus.HTRANS),    64'(0));
        check({tag, "_hmastlock"},  64'(bus.HMASTLOCK), 64'(0));
        check({tag, "_hwdata"},     64'(bus.HWDATA),    64'(0));
        check({tag, "_resp_valid"}, 64'(resp_valid),    64'(0));
        check({tag, "_resp_rdata"}, 64'(resp_rdata),    64'(0));
        check({tag, "_resp_err"},   64'(resp_err),      64'(0));
        check({tag, "_cmd_ready"},  64'(cmd_ready),     64'(0));
    endtask

    // ---------------- slave model + monitors (falling edge) ----------------
    bit            prev_hready = 1'b1;
    logic [1:0]    prev_htrans = 2'b00;
    logic [AW-1:0] prev_haddr  = '0;
    logic          prev_hwrite = 1'b0;
    logic [2:0]    prev_hsize  = '0;
    logic [2:0]    prev_hburst = '0;
    bit            dp_active   = 1'b0;
    logic [AW-1:0] dp_addr     = '0;
    logic          dp_write    = 1'b0;
    int            dp_beat     = 0;
    int            dp_waits    = 0;
    bit            dp_err      = 1'b0;
    bit            err_stage   = 1'b0;
    int            low_cnt     = 0;
    logic [DW:0]   exp_r;
    logic [40:0]   exp_a;
    int            exp_lat;

    initial begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = '0;
    end

    always @(negedge HCLK) begin
        if (HRESET) begin
            exp_q.delete();
            exp_addr_q.delete();
            lat_q.delete();
            bus.HREADY  = 1'b1;
            bus.HRESP   = 1'b0;
            bus.HRDATA  = '0;
            prev_hready = 1'b1;
            prev_htrans = 2'b00;
            dp_active   = 1'b0;
            low_cnt     = 0;
        end else begin
            // Close out the previous cycle: a completed HREADY edge retires the
            // data phase and turns the sampled address phase into the next one.
            if (prev_hready) begin
                if (prev_htrans != 2'b00) begin
                    if (exp_addr_q.size() == 0) begin
                        check("unexpected_addr_phase", 64'(prev_htrans), 64'(0));
                    end else begin
                        exp_a = exp_addr_q.pop_front();
                        check("addr_phase",
                              64'({prev_htrans, prev_hwrite, prev_hsize, prev_hburst, prev_haddr}),
                              64'(exp_a));
                    end
                    dp_active = 1'b1;
                    dp_addr   = prev_haddr;
                    dp_write  = prev_hwrite;
                    dp_beat   = (prev_htrans == 2'b10) ? 0 : dp_beat + 1;
                    dp_waits  = (dp_beat == wait_beat) ? wait_n
                              : (rand_waits ? int'($urandom_range(0, 2)) : 0);
                    dp_err    = (dp_beat == err_beat);
                    err_stage = 1'b0;
                end else begin
                    dp_active = 1'b0;
                end
            end

            // Response monitor.
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 64'(resp_valid), 64'(0));
                end else begin
                    exp_r   = exp_q.pop_front();
                    exp_lat = lat_q.pop_front();
                    check("resp", 64'({resp_err, resp_rdata}), 64'(exp_r));
                    check("resp_latency", 64'(cyc - accept_cyc), 64'(exp_lat + low_cnt));
                end
                low_cnt = 0;
            end

            // Sample the address phase presented in this cycle.
            prev_htrans = bus.HTRANS;
            prev_haddr  = bus.HADDR;
            prev_hwrite = bus.HWRITE;
            prev_hsize  = bus.HSIZE;
            prev_hburst = bus.HBURST;

            // Slave response for the current data phase.
            if (dp_active) begin
                if (dp_write) check("hwdata", 64'(bus.HWDATA), 64'(cur_wdata));
                bus.HRDATA = dp_write ? '0 : (32'hABCD0000 + dp_addr);
                if (dp_waits > 0) begin
                    bus.HREADY = 1'b0;
                    bus.HRESP  = 1'b0;
                    dp_waits--;
                    low_cnt++;
                end else if (dp_err && !err_stage) begin
                    bus.HREADY = 1'b0;
                    bus.HRESP  = 1'b1;
                    err_stage  = 1'b1;
                    low_cnt++;
                end else begin
                    bus.HREADY = 1'b1;
                    bus.HRESP  = dp_err;
                end
            end else begin
                bus.HREADY = 1'b1;
                bus.HRESP  = 1'b0;
                bus.HRDATA = '0;
            end
            prev_hready = bus.HREADY;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 200000", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int len, pick, eb, le;
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        check_reset_vals("reset");
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;
        check("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));

        // Directed cases.
        rand_waits = 1'b0;
        issue(1'b0, 32'h0000_0100, 32'h0,         1,  2, -1, -1, 0);
        issue(1'b1, 32'h0000_0200, 32'hDEADBEEF,  1,  2, -1, -1, 0);
        issue(1'b0, 32'h0000_1000, 32'h0,         4,  2, -1, -1, 0);
        issue(1'b1, 32'h0000_2000, 32'h12345678,  4,  2, -1,  2, 2);
        issue(1'b1, 32'h0000_4000, 32'hCAFEF00D,  4,  2,  1, -1, 0);
        issue(1'b0, 32'h0000_0500, 32'h0,         0,  7, -1, -1, 0);
        issue(1'b0, 32'h0000_0600, 32'h0,        16,  1, -1, -1, 0);
        issue(1'b1, 32'h0000_0700, 32'h0BADF00D,  8,  0,  7, -1, 0);
        issue(1'b0, 32'h0000_0800, 32'h0,         3,  2,  0, -1, 0);
        issue(1'b0, 32'hFFFF_FFF8, 32'h0,         4,  2, -1, -1, 0);
        wait_ready();

        // Reset in the middle of a burst: no response, outputs back to reset values.
        issue(1'b0, 32'h0000_3000, 32'h0, 8, 2, -1, -1, 0);
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        check_reset_vals("midburst_reset");
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;
        check("cmd_ready_after_midburst_reset", 64'(cmd_ready), 64'(1));
        repeat (12) @(posedge HCLK);
        #1;

        // Randomized commands with random wait states and errors.
        rand_waits = 1'b1;
        for (int i = 0; i < 40; i++) begin
            pick = $urandom_range(0, 5);
            case (pick)
                0:       len = 0;
                1:       len = 1;
                2:       len = 4;
                3:       len = 8;
                4:       len = 16;
                default: len = $urandom_range(2, 20);
            endcase
            le = (len == 0) ? 1 : len;
            eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, le - 1)) : -1;
            issue(1'($urandom_range(0, 1)), $urandom, $urandom, len,
                  int'($urandom_range(0, 7)), eb, -1, 0);
        end
        wait_ready();
        repeat (5) @(posedge HCLK);
        #1;
        check("resp_queue_drained", 64'(exp_q.size()), 64'(0));
        check("addr_queue_drained", 64'(exp_addr_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
